pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 34 +++
 rtl/pc_sequencer_jno_wait_timer.sv | 44 ++++
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared definitions for the program-counter sequencer. This
//               package holds the opcode values of a fetched program line,
//               the 3-bit sequencer state encoding, and a small decode
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    // Opcode field of a fetched program line
    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_JNO = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_STP = 2'b11;

    // Sequencer state encoding
    localparam int unsigned c_state_w = 3;

    localparam logic [c_state_w-1:0] c_st_idle   = 3'd0;
    localparam logic [c_state_w-1:0] c_st_fetch  = 3'd1;
    localparam logic [c_state_w-1:0] c_st_decode = 3'd2;
    localparam logic [c_state_w-1:0] c_st_exec   = 3'd3;
    localparam logic [c_state_w-1:0] c_st_jwait  = 3'd4;
    localparam logic [c_state_w-1:0] c_st_halt   = 3'd5;

    // Returns true for opcodes that need a datapath execute strobe
    function automatic logic is_exec_op(input logic [1:0] op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_jno_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : jno_wait_timer
// Description : Counts consecutive cycles spent waiting for a JNO check
//               window. o_expired is asserted during the WAIT_MAX-th
//               consecutive enabled cycle. The count clears whenever
//               i_en drops.
// Ports       : clk       - clock
//               rst       - synchronous active-high reset
//               i_en      - sequencer is in its jump-wait state
//               o_expired - wait budget used up this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module jno_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_expired
);

    // The count only has to reach WAIT_MAX-1
    localparam int c_cnt_w = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WAIT_MAX - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_at_last;

    assign w_at_last = (r_count == c_last);
    assign o_expired = i_en && w_at_last;

    // Saturate at the last value. The sequencer leaves the wait state on
    // expiry, so the count never needs to wrap.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_count <= '0;
        end else if (!w_at_last) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer with the states
//               IDLE/FETCH/DECODE/EXEC/JWAIT/HALT. It fetches a line,
//               decodes the opcode, and then does one of the following:
//                 - executes INC/DEC,
//                 - waits for the JNO check window and conditionally jumps,
//                 - halts.
//               Optional build macro JNO_TIMEOUT_EN bounds the JNO wait to
//               WAIT_MAX cycles. After that many cycles the jump is treated
//               as not taken.
// Ports       : pulses      - clock (rising edge)
//               r           - synchronous active-high reset
//               run         - start/continue execution
//               instruct    - opcode of fetched line
//               target      - jump address of fetched line
//               enabling    - JNO check enable
//               openpulse   - JNO sample window
//               sta         - stop/halt request
//               reg_nonzero - selected register non-zero
//               pc          - current program line address
//               fetch       - line read strobe
//               exec        - INC/DEC execute strobe
//               jump_taken  - pc loaded from target strobe
//               halted      - sequencer in HALT
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W     = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic            pulses,
    input  logic            r,
    input  logic            run,
    input  logic [1:0]      instruct,
    input  logic [PC_W-1:0] target,
    input  logic            enabling,
    input  logic            openpulse,
    input  logic            sta,
    input  logic            reg_nonzero,
    output logic [PC_W-1:0] pc,
    output logic            fetch,
    output logic            exec,
    output logic            jump_taken,
    output logic            halted
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next_state;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      w_next_pc;
    logic [PC_W-1:0]      w_pc_inc;
    logic [PC_W-1:0]      r_target;
    logic [1:0]           r_op;
    logic                 w_in_jwait;
    logic                 w_window;
    logic                 w_timeout;

    // A zero wait budget would make every JNO fall through at once
    if (WAIT_MAX < 1) begin : g_wait_max_check
        $error("pc_sequencer: WAIT_MAX must be at least 1");
    end

    assign pc         = r_pc;
    assign w_pc_inc   = r_pc + PC_W'(1);      // wraps modulo 2^PC_W
    assign w_in_jwait = (r_state == c_st_jwait);
    // openpulse is only meaningful while the check is enabled
    assign w_window   = enabling && openpulse;

`ifdef JNO_TIMEOUT_EN
    jno_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_jno_wait_timer (
        .clk       (pulses),
        .rst       (r),
        .i_en      (w_in_jwait),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // State, pc and latched operand registers
    always_ff @(posedge pulses) begin
        if (r) begin
            r_state  <= c_st_idle;
            r_pc     <= '0;
            r_op     <= '0;
            r_target <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (r_state == c_st_decode) begin
                r_op     <= instruct;
                r_target <= target;
            end
        end
    end

    // Next-state and next-pc logic
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        // A stop request overrides every transition and freezes pc
        if (sta && (r_state != c_st_halt)) begin
            w_next_state = c_st_halt;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (run) begin
                        w_next_state = c_st_fetch;
                    end
                end
                c_st_fetch: begin
                    w_next_state = c_st_decode;
                end
                c_st_decode: begin
                    if (instruct == OP_STP) begin
                        w_next_state = c_st_halt;
                    end else if (instruct == OP_JNO) begin
                        w_next_state = c_st_jwait;
                    end else begin
                        w_next_state = c_st_exec;
                    end
                end
                c_st_exec: begin
                    w_next_pc    = w_pc_inc;
                    w_next_state = run ? c_st_fetch : c_st_idle;
                end
                c_st_jwait: begin
                    // A valid window wins over a timeout in the same cycle
                    if (w_window) begin
                        w_next_pc    = reg_nonzero ? r_target : w_pc_inc;
                        w_next_state = c_st_fetch;
                    end else if (w_timeout) begin
                        w_next_pc    = w_pc_inc;
                        w_next_state = c_st_fetch;
                    end
                end
                c_st_halt: begin
                    w_next_state = c_st_halt;
                end
                default: begin
                    w_next_state = c_st_idle;
                end
            endcase
        end
    end

    // Strobes are decoded from exclusive states, so they never overlap
    always_comb begin
        fetch      = (r_state == c_st_fetch);
        exec       = (r_state == c_st_exec) && is_exec_op(r_op);
        jump_taken = w_in_jwait && !sta && w_window && reg_nonzero;
        halted     = (r_state == c_st_halt);
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer. The program
//               memory is modelled as an array indexed by pc. Each expected
//               fetch address is queued before the stimulus that causes it.
//               A monitor compares every fetch against the queue.
//               Build macro JNO_TIMEOUT_EN selects which JNO-wait behaviour
//               is expected.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int PC_W     = 5;
    localparam int WAIT_MAX = 15;

    logic            pulses = 1'b0;
    logic            r;
    logic            run;
    logic [1:0]      instruct;
    logic [PC_W-1:0] target;
    logic            enabling;
    logic            openpulse;
    logic            sta;
    logic            reg_nonzero;
    logic [PC_W-1:0] pc;
    logic            fetch;
    logic            exec;
    logic            jump_taken;
    logic            halted;

    logic [1:0]      prog_op  [32];
    logic [PC_W-1:0] prog_tgt [32];
    logic [PC_W-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .PC_W     (PC_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .pulses      (pulses),
        .r           (r),
        .run         (run),
        .instruct    (instruct),
        .target      (target),
        .enabling    (enabling),
        .openpulse   (openpulse),
        .sta         (sta),
        .reg_nonzero (reg_nonzero),
        .pc          (pc),
        .fetch       (fetch),
        .exec        (exec),
        .jump_taken  (jump_taken),
        .halted      (halted)
    );

    always #5 pulses = ~pulses;

    // Program memory read at the current pc
    assign instruct = prog_op[pc];
    assign target   = prog_tgt[pc];

    task automatic tick();
        @(negedge pulses);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        enabling    = 1'b0;
        openpulse   = 1'b0;
        sta         = 1'b0;
        reg_nonzero = 1'b0;
    endtask

    // Fetch scoreboard and strobe exclusivity monitor
    always @(negedge pulses) begin : mon
        logic [PC_W-1:0] exp_pc;
        checks++;
        assert ($countones({fetch, exec, jump_taken}) <= 1) else begin
            errors++;
            $error("FAIL strobe_onehot: observed=%b expected=at most one high", {fetch, exec, jump_taken});
        end
        if (fetch === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_fetch: observed fetch at pc=%0d expected=no fetch", pc);
            end
            if (exp_q.size() > 0) begin
                exp_pc = exp_q.pop_front();
                checks++;
                assert (pc === exp_pc) else begin
                    errors++;
                    $error("FAIL sb_fetch_pc: observed=%0d expected=%0d", pc, exp_pc);
                end
            end
        end
    end

    // Reset, then run lines 0-3 (INC) up to the JNO at line 4.
    // On return the bench sits at the first JWAIT cycle (cycle 15 after run).
    task automatic run_to_jwait(input bit timing);
        r   = 1'b1;
        run = 1'b0;
        clear_inputs();
        tick();
        r   = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(PC_W'(k));
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (timing && c <= 9) begin
                chk($sformatf("fetch_c%0d", c), fetch, (c == 1 || c == 4 || c == 7));
                chk($sformatf("exec_c%0d", c), exec, (c == 3 || c == 6 || c == 9));
            end
            if (timing && c == 10) chk("pc_after_three_inc", pc, 3);
        end
    endtask

    initial begin
        r   = 1'b1;
        run = 1'b0;
        clear_inputs();
        for (int i = 0; i < 32; i++) begin
            prog_op[i]  = 2'b00;
            prog_tgt[i] = '0;
        end
        prog_op[4]  = 2'b01;   // JNO -> 9
        prog_tgt[4] = 5'd9;
        prog_op[9]  = 2'b10;   // DEC

        repeat (2) tick();
        chk("reset_pc", pc, 0);
        chk("reset_fetch", fetch, 0);
        chk("reset_exec", exec, 0);
        chk("reset_jump", jump_taken, 0);
        chk("reset_halted", halted, 0);

        // JNO taken on the 3rd JWAIT cycle; an unenabled openpulse is ignored
        run_to_jwait(1'b1);
        exp_q.push_back(5'd9);
        openpulse   = 1'b1;
        reg_nonzero = 1'b1;
        #1 chk("jno_ignored_open", jump_taken, 0);
        tick();
        chk("jno_wait2_pc", pc, 4);
        chk("jno_wait2_fetch", fetch, 0);
        openpulse = 1'b0;
        tick();
        enabling  = 1'b1;
        openpulse = 1'b1;
        #1 chk("jno_taken_strobe", jump_taken, 1);
        chk("jno_taken_pc_hold", pc, 4);
        tick();
        clear_inputs();
        chk("jno_taken_fetch", fetch, 1);
        chk("jno_taken_pc", pc, 9);

        // JNO not taken
        run_to_jwait(1'b0);
        exp_q.push_back(5'd5);
        tick();
        tick();
        enabling  = 1'b1;
        openpulse = 1'b1;
        #1 chk("jno_nt_strobe", jump_taken, 0);
        tick();
        clear_inputs();
        chk("jno_nt_fetch", fetch, 1);
        chk("jno_nt_pc", pc, 5);

        // Stop during JWAIT beats a simultaneous valid window
        run_to_jwait(1'b0);
        sta         = 1'b1;
        enabling    = 1'b1;
        openpulse   = 1'b1;
        reg_nonzero = 1'b1;
        #1 chk("sta_blocks_jump", jump_taken, 0);
        tick();
        clear_inputs();
        chk("sta_halted", halted, 1);
        chk("sta_pc_frozen", pc, 4);
        repeat (20) tick();
        chk("halt_sticky", halted, 1);
        chk("halt_pc_frozen", pc, 4);
        r = 1'b1;
        tick();
        chk("halt_reset_halted", halted, 0);
        chk("halt_reset_pc", pc, 0);

        // Reset mid-JWAIT discards a simultaneous window
        run_to_jwait(1'b0);
        r           = 1'b1;
        enabling    = 1'b1;
        openpulse   = 1'b1;
        reg_nonzero = 1'b1;
        tick();
        chk("rst_jwait_pc", pc, 0);
        chk("rst_jwait_jump", jump_taken, 0);
        chk("rst_jwait_halted", halted, 0);
        clear_inputs();

        // JWAIT with no window
        run_to_jwait(1'b0);
`ifdef JNO_TIMEOUT_EN
        exp_q.push_back(5'd5);
        repeat (WAIT_MAX - 1) tick();
        chk("timeout_last_wait_fetch", fetch, 0);
        chk("timeout_last_wait_pc", pc, 4);
        tick();
        chk("timeout_fetch", fetch, 1);
        chk("timeout_pc", pc, 5);
`else
        repeat (100) tick();
        chk("nowait_pc", pc, 4);
        chk("nowait_fetch", fetch, 0);
        chk("nowait_halted", halted, 0);
        exp_q.push_back(5'd9);
        enabling    = 1'b1;
        openpulse   = 1'b1;
        reg_nonzero = 1'b1;
        #1 chk("nowait_still_jwait", jump_taken, 1);
        tick();
        clear_inputs();
        chk("nowait_jump_pc", pc, 9);
`endif

        // pc wrap 31 -> 0, then run=0 during EXEC returns to IDLE
        prog_op[4] = 2'b00;
        r   = 1'b1;
        run = 1'b0;
        tick();
        r   = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 32; k++) exp_q.push_back(PC_W'(k));
        exp_q.push_back(5'd0);
        for (int c = 1; c <= 99; c++) begin
            tick();
            if (c == 96) begin
                chk("wrap_exec31", exec, 1);
                chk("wrap_pc31", pc, 31);
            end
            if (c == 97) begin
                chk("wrap_fetch0", fetch, 1);
                chk("wrap_pc0", pc, 0);
            end
        end
        run = 1'b0;
        tick();
        chk("idle_pc", pc, 1);
        chk("idle_fetch", fetch, 0);
        repeat (3) tick();
        chk("idle_stays_fetch", fetch, 0);
        chk("idle_stays_pc", pc, 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
